ioexp_master: RTL and testbench
===============================

# ioexp_master

Bus-master end of the 8243-style nibble expander protocol on P2/PROG: it plays the meter MCU's part, driving PROG and the P2 nibble bus to issue read, write, OR and AND transactions to an expander port (P4–P7). A simple valid/ready command port feeds it, and it returns read nibbles on a one-cycle done strobe. It is used as the stimulus master in front of `ioexp` in the bridge test harness and in a standalone MCU-side bus emulator. The top level owns the P2 tri-state buffer: P2 = `p2_oe ? p2o : 'z`.

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles that the address nibble is driven with `prog_n` high, before the PROG falling edge. Must be ≥1.
- `HOLD_CYC`, default 2: cycles of address hold after PROG falls. Also the cycles of data hold after PROG rises. Must be ≥1.
- `PULSE_CYC`, default 4: cycles of the data phase with `prog_n` low. Must be ≥2; a smaller value is an elaboration error.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: system clock (7.3728 MHz).
  - `rst_n` in 1: asynchronous, active-low reset.
- Command port:
  - `cmd_valid` in 1: command request.
  - `cmd_ready` out 1: the block accepts a command when `cmd_valid & cmd_ready`.
  - `cmd_op` in 2: operation. 00 = read, 01 = write, 10 = OR, 11 = AND.
  - `cmd_port` in 2: target port. 00 = P4 … 11 = P7.
  - `cmd_data` in 4: write/OR/AND nibble. Ignored for read.
- Response:
  - `done` out 1: one-cycle pulse at the end of every transaction.
  - `rsp_data` out 4: read nibble. Valid while `done` is high after a read; holds its value until the next read completes.
- P2/PROG bus:
  - `p2i` in 4: P2 pins as seen from the bus.
  - `p2o` out 4: P2 drive value.
  - `p2_oe` out 1: P2 drive enable.
  - `prog_n` out 1: PROG strobe, active-low.
- `busy` out 1: high in every state except IDLE.

## Operation
- All outputs are registered. Values held during reset: `cmd_ready`=0, `done`=0, `rsp_data`=0, `p2o`=0, `p2_oe`=0, `prog_n`=1, `busy`=0. After reset releases, `cmd_ready` is 1 in IDLE.
- A command is latched on acceptance. Later changes on the command inputs have no effect on an in-flight transaction.
- State sequence: IDLE → ADDR → AHOLD → DATA → DHOLD → IDLE. A single down-counter, reloaded on each state entry, times the states.
  - IDLE: `prog_n`=1, `p2_oe`=0, `cmd_ready`=1.
  - ADDR (`SETUP_CYC` cycles): `p2_oe`=1, `p2o`={op,port}, `prog_n`=1.
  - AHOLD (`HOLD_CYC` cycles): `prog_n`=0, `p2o`={op,port}, `p2_oe`=1.
  - DATA (`PULSE_CYC` cycles): `prog_n`=0.
    - Write/OR/AND: `p2o`=data, `p2_oe`=1.
    - Read: `p2_oe`=0, so the bus turns around to the expander.
  - DHOLD (`HOLD_CYC` cycles): `prog_n`=1.
    - Write/OR/AND: `p2o`=data, `p2_oe`=1.
    - Read: `p2_oe`=0.
  - On the DHOLD → IDLE transition, `done`=1 for exactly one cycle. For a read, `rsp_data` updates on that same edge.
- Read sampling:
  - `p2i` is registered once every cycle into `p2i_q`.
  - The read nibble is captured from `p2i_q` on the edge at which `prog_n` goes high (end of DATA). It therefore equals `p2i` as it was one cycle before PROG rises.
  - That capture is held internally and transferred to `rsp_data` with `done`.
- `cmd_ready` is 0 in every non-IDLE state. A command presented during a transaction waits, with no loss and no error.
- Back-to-back commands: `cmd_ready`=1 in the same cycle as `done`, so the next command can be accepted there. The minimum PROG-high gap between transactions is `HOLD_CYC`+1+`SETUP_CYC` cycles.
- Reset mid-transaction: the block returns to IDLE immediately and asynchronously. `prog_n` goes to 1 and `p2_oe` to 0 with no glitch low. No `done` is issued, and the aborted command is dropped.

## Timing
- Let E0 be the edge at which the command is accepted.
  - E0: `p2_oe`=1 and the address is on `p2o`.
  - E0+S: `prog_n` falls (S = `SETUP_CYC`).
  - E0+S+H: the data phase starts (H = `HOLD_CYC`).
  - E0+S+H+P: `prog_n` rises (P = `PULSE_CYC`).
  - E0+S+2H+P: `done`=1 for one cycle.
- Defaults: `prog_n` is low for 6 cycles, and `done` asserts 10 cycles after acceptance.
- The address is stable for ≥`SETUP_CYC` cycles before PROG falls and ≥`HOLD_CYC` cycles after.
- Write data is stable throughout DATA and for `HOLD_CYC` cycles after PROG rises.
- For a read, the master releases the bus in the same cycle that the address hold ends, so the bus has a `PULSE_CYC`−1 cycle turnaround margin before sampling.

## Test plan
- Reset with `cmd_valid`=1 held → every output stays at its reset value while `rst_n`=0. After release, the command is accepted on the first edge with `cmd_ready`=1.
- Write op=01, port=10, data=0xA, default parameters:
  - `p2o`=0x6 for 2 cycles, then `prog_n` low for 6 cycles.
  - `p2o`=0xA from E0+4 through E0+9.
  - `done` at E0+10, with `p2_oe`=0 after that.
- Read op=00, port=01; an expander model drives 0x5 while PROG is low:
  - `p2o`=0x1 during the address phase, and `p2_oe` drops at E0+4.
  - `rsp_data`=0x5 with `done` at E0+10.
- Back-to-back: an AND (0x3 to P7) then an OR (0xC to P4), with `cmd_valid` held:
  - The second command is accepted in the `done` cycle.
  - PROG is high for exactly 5 cycles between the two pulses.
  - The address nibbles are 0xF then 0x8.
- `rst_n` asserted during DATA of a write → `prog_n`=1 and `p2_oe`=0 immediately, with no `done`. The next read completes normally.
- Parameters `SETUP_CYC`=1, `HOLD_CYC`=1, `PULSE_CYC`=2 → `prog_n` low for 3 cycles, `done` at E0+5, and the read nibble is sampled correctly.

Source files
------------

// File: rtl/ioexp_master.sv
// Purpose : 8243-style nibble expander bus master; issues read/write/OR/AND on P2/PROG from a valid/ready command port.
// Latency : command accepted at E0, done pulse at E0+SETUP_CYC+2*HOLD_CYC+PULSE_CYC; read nibble on rsp_data with done.
// Backpr. : cmd_ready is high only in IDLE (including the done cycle); a waiting command is held off, never dropped.
//
// Ports:
//   clk, rst_n                         system clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_op[1:0], cmd_port[1:0], cmd_data[3:0]
//                                      operation (00 rd,01 wr,10 or,11 and), port P4..P7, nibble
//   done, rsp_data[3:0]                end-of-transaction strobe, last read nibble
//   p2i[3:0], p2o[3:0], p2_oe, prog_n  expander bus (tri-state buffer lives above this block)
//   busy                               high outside IDLE
module ioexp_master #(
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int PULSE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_port,
    input  logic [3:0] cmd_data,
    output logic       done,
    output logic [3:0] rsp_data,
    input  logic [3:0] p2i,
    output logic [3:0] p2o,
    output logic       p2_oe,
    output logic       prog_n,
    output logic       busy
);

    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("ioexp_master: SETUP_CYC must be >= 1");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("ioexp_master: HOLD_CYC must be >= 1");
    end
    if (PULSE_CYC < 2) begin : g_bad_pulse
        $error("ioexp_master: PULSE_CYC must be >= 2");
    end

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_AHOLD = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DHOLD = 3'd4;

    localparam logic [1:0] OP_READ = 2'b00;

    // Counter reload values: a state lasting N cycles loads N-1 and leaves at 0.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);

    logic [2:0] state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] op_q, port_q;
    logic [3:0] data_q;
    logic [3:0] p2i_q;
    logic [3:0] rd_q;

    logic       accept;
    logic [1:0] op_nx, port_nx;
    logic [3:0] data_nx;
    logic       ready_nx, prog_n_nx, p2_oe_nx, done_nx;
    logic [3:0] p2o_nx;

    assign accept = cmd_valid & cmd_ready;

    // Command fields as they will be after this edge, so outputs can be
    // registered already in the acceptance cycle.
    assign op_nx   = accept ? cmd_op   : op_q;
    assign port_nx = accept ? cmd_port : port_q;
    assign data_nx = accept ? cmd_data : data_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_ADDR;
                    cnt_nx   = SETUP_LD;
                end
            end
            ST_ADDR: begin
                if (cnt == 8'd0) begin
                    state_nx = ST_AHOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ST_AHOLD: begin
                if (cnt == 8'd0) begin
                    state_nx = ST_DATA;
                    cnt_nx   = PULSE_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ST_DATA: begin
                if (cnt == 8'd0) begin
                    state_nx = ST_DHOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ST_DHOLD: begin
                if (cnt == 8'd0) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Output values for the state being entered; everything is registered.
    always_comb begin
        ready_nx  = (state_nx == ST_IDLE);
        prog_n_nx = !((state_nx == ST_AHOLD) || (state_nx == ST_DATA));
        done_nx   = (state == ST_DHOLD) && (state_nx == ST_IDLE);
        p2_oe_nx  = 1'b0;
        p2o_nx    = p2o;
        case (state_nx)
            ST_ADDR, ST_AHOLD: begin
                p2_oe_nx = 1'b1;
                p2o_nx   = {op_nx, port_nx};
            end
            ST_DATA, ST_DHOLD: begin
                // Reads release the bus as soon as the address hold ends.
                p2_oe_nx = (op_nx != OP_READ);
                p2o_nx   = data_nx;
            end
            default: begin
                p2_oe_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            op_q      <= 2'd0;
            port_q    <= 2'd0;
            data_q    <= 4'd0;
            p2i_q     <= 4'd0;
            rd_q      <= 4'd0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            rsp_data  <= 4'd0;
            p2o       <= 4'd0;
            p2_oe     <= 1'b0;
            prog_n    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            p2i_q     <= p2i;
            op_q      <= op_nx;
            port_q    <= port_nx;
            data_q    <= data_nx;
            // Sample on the PROG rising edge; the registered pin value is one cycle old.
            if ((state == ST_DATA) && (state_nx == ST_DHOLD)) begin
                rd_q <= p2i_q;
            end
            if (done_nx && (op_q == OP_READ)) begin
                rsp_data <= rd_q;
            end
            cmd_ready <= ready_nx;
            done      <= done_nx;
            p2o       <= p2o_nx;
            p2_oe     <= p2_oe_nx;
            prog_n    <= prog_n_nx;
            busy      <= !ready_nx;
        end
    end

endmodule

// File: tb/tb_ioexp_master.sv
module tb_ioexp_master;

    localparam int S = 2;
    localparam int H = 2;
    localparam int P = 4;
    localparam int T = S + 2 * H + P;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] port;
        logic [3:0] d;
        logic [3:0] rd;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [1:0] cmd_port = 2'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       done;
    logic [3:0] rsp_data;
    logic [3:0] p2i;
    logic [3:0] p2o;
    logic       p2_oe;
    logic       prog_n;
    logic       busy;

    logic       f_valid = 1'b0;
    logic       f_ready;
    logic       f_done;
    logic [3:0] f_rsp;
    logic [3:0] f_p2i;
    logic [3:0] f_p2o;
    logic       f_p2_oe;
    logic       f_prog_n;
    logic       f_busy;

    int   n_chk = 0;
    int   n_err = 0;
    txn_t sb_q[$];
    logic [3:0] f_q[$];
    txn_t cur = '0;
    bit   act = 1'b0;
    int   k = 0;
    int   drv_k = -1;
    logic [3:0] last_rsp = 4'd0;

    always #5 clk = ~clk;

    ioexp_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_port(cmd_port), .cmd_data(cmd_data),
        .done(done), .rsp_data(rsp_data),
        .p2i(p2i), .p2o(p2o), .p2_oe(p2_oe), .prog_n(prog_n),
        .busy(busy)
    );

    ioexp_master #(.SETUP_CYC(1), .HOLD_CYC(1), .PULSE_CYC(2)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(f_valid), .cmd_ready(f_ready),
        .cmd_op(2'b00), .cmd_port(2'b10), .cmd_data(4'h0),
        .done(f_done), .rsp_data(f_rsp),
        .p2i(f_p2i), .p2o(f_p2o), .p2_oe(f_p2_oe), .prog_n(f_prog_n),
        .busy(f_busy)
    );

    // Expander model: only the cycle that lands in the sampling register
    // carries the real nibble, everything else in DATA is its complement.
    assign p2i   = p2_oe ? p2o : ((drv_k == S + H + P - 2) ? cur.rd : ~cur.rd);
    assign f_p2i = f_p2_oe ? f_p2o : (f_prog_n ? 4'h0 : 4'h9);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor: {busy, cmd_ready, prog_n, p2_oe, p2o, done, rsp_data}
    always @(negedge clk) begin : mon
        logic       e_busy, e_rdy, e_prog, e_oe, e_done;
        logic [3:0] e_p2o, e_rsp;
        if (!rst_n) begin
            act      = 1'b0;
            drv_k    = -1;
            last_rsp = 4'd0;
            check("reset_state", {3'b0, busy, cmd_ready, prog_n, p2_oe, p2o, done, rsp_data},
                  {3'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0});
        end else begin
            e_busy = 1'b0; e_rdy = 1'b1; e_prog = 1'b1; e_oe = 1'b0;
            e_done = 1'b0; e_p2o = 4'h0; e_rsp = last_rsp;
            if (act) begin
                e_busy = 1'b1; e_rdy = 1'b0; e_p2o = {cur.op, cur.port};
                if (k < S) begin
                    e_oe = 1'b1;
                end else if (k < S + H) begin
                    e_prog = 1'b0; e_oe = 1'b1;
                end else if (k < S + H + P) begin
                    e_prog = 1'b0; e_oe = (cur.op != 2'b00); e_p2o = cur.d;
                end else if (k < T) begin
                    e_oe = (cur.op != 2'b00); e_p2o = cur.d;
                end else begin
                    e_busy = 1'b0; e_rdy = 1'b1; e_done = 1'b1;
                    if (cur.op == 2'b00) e_rsp = cur.rd;
                end
            end
            check(act ? "txn_cycle" : "idle_cycle",
                  {3'b0, busy, cmd_ready, prog_n, p2_oe, (e_oe ? p2o : 4'h0), done, rsp_data},
                  {3'b0, e_busy, e_rdy, e_prog, e_oe, (e_oe ? e_p2o : 4'h0), e_done, e_rsp});
            last_rsp = e_rsp;
            if (act) begin
                drv_k = k;
                k++;
                if (k > T) begin
                    act   = 1'b0;
                    drv_k = -1;
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_accept", 16'd1, 16'd0);
                end else begin
                    cur = sb_q.pop_front();
                    act = 1'b1;
                    k   = 0;
                end
            end
        end
    end

    task automatic present(input logic [1:0] op, input logic [1:0] port,
                           input logic [3:0] d, input logic [3:0] rd);
        cmd_op    = op;
        cmd_port  = port;
        cmd_data  = d;
        cmd_valid = 1'b1;
        sb_q.push_back('{op, port, d, rd});
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic wait_accept(input bit keep);
        int n = 0;
        while (!(rst_n && cmd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 16'd1, 16'd0);
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    initial begin
        int lowcnt;
        int done_k;
        int n;

        // Reset with a command already pending.
        present(2'b01, 2'b10, 4'hA, 4'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_accept(1'b0);
        repeat (12) @(negedge clk);

        // Read from P5.
        present(2'b00, 2'b01, 4'h0, 4'h5);
        wait_accept(1'b0);
        repeat (12) @(negedge clk);

        // Back-to-back AND then OR; the inputs change mid-flight.
        present(2'b11, 2'b11, 4'h3, 4'h0);
        wait_accept(1'b1);
        present(2'b10, 2'b00, 4'hC, 4'h0);
        wait_accept(1'b0);
        repeat (12) @(negedge clk);

        // Reset in the middle of a write's DATA phase.
        present(2'b01, 2'b00, 4'h7, 4'h0);
        wait_accept(1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", {13'b0, prog_n, p2_oe, done}, {13'b0, 1'b1, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Read after the abort completes normally.
        present(2'b00, 2'b11, 4'h0, 4'hC);
        wait_accept(1'b0);
        repeat (14) @(negedge clk);
        check("sb_drained", 16'(sb_q.size()), 16'd0);

        // Minimum timing parameters.
        f_valid = 1'b1;
        f_q.push_back(4'h9);
        n = 0;
        while (!f_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("fast_accept_timeout", 16'd1, 16'd0);
        @(posedge clk);
        #1 f_valid = 1'b0;
        lowcnt = 0;
        done_k = -1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (!f_prog_n) lowcnt++;
            if (f_done && done_k < 0) begin
                done_k = j;
                if (f_q.size() != 0) check("fast_rsp", {12'b0, f_rsp}, {12'b0, f_q.pop_front()});
            end
        end
        check("fast_prog_low", 16'(lowcnt), 16'd3);
        check("fast_done_cycle", 16'(done_k), 16'd5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
